bus_grant_ctrl: RTL

//  Round-robin grant controller for the shared serial system bus. Sits in front of the

---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/bus_grant_ctrl_if.sv | 25 ++
 rtl/bus_grant_ctrl_rr_pick.sv | 30 +++
 rtl/bus_grant_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types for the system-bus arbiter.
// The grant controller and the arbiter datapath both use these types.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } grant_state_t;

    // Hold-counter width. It is never below 1, so the watchdog-disabled build still elaborates.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_grant_ctrl_if.sv
// Request/grant handshake between the bus masters and the grant controller.
// The master modport is the requester side. The slave modport is the controller side.
interface bus_grant_ctrl_if #(
    parameter int NUM_MASTERS = 2
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] done;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   bus_busy;
    logic                   timeout;

    modport master (
        output req, done,
        input  grant, grant_idx, bus_busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, bus_busy, timeout
    );

endinterface

// File: rtl/bus_grant_ctrl_rr_pick.sv
// Combinational round-robin picker.
// The search starts at last_i+1 and wraps, so last_i has the lowest priority.
module rr_priority_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(last_i) + k) % N;
            cand_idx = IDX_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/bus_grant_ctrl.sv
// Round-robin grant controller for the shared serial system bus.
// A single registered one-hot grant is given out, and a watchdog revokes long holds.
module bus_grant_ctrl
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    bus_grant_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

    grant_state_t           state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             normal_end;
    logic             watchdog_hit;

    rr_priority_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (bus.req),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    assign normal_end   = bus.done[idx_q] | ~bus.req[idx_q];
    assign watchdog_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE, RELEASE: begin
                // RELEASE re-arbitrates directly, so back-to-back requests skip IDLE.
                state_d = IDLE;
                grant_d = '0;
                if (pick_vld) begin
                    state_d = GRANT;
                    grant_d = NUM_MASTERS'(1) << pick_idx;
                    idx_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (normal_end || watchdog_hit) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    timeout_d = watchdog_hit & ~normal_end;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            last_q    <= LAST_RST;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.bus_busy  = (state_q != IDLE);
    assign bus.timeout   = timeout_q;

endmodule
